// File: rtl/data_mem_arbiter.sv
// Purpose : round-robin arbiter sharing one backing-store port between the
//           fetch stage (read-only) and the memory stage (read/write).
// Latency : 3 cycles req->ready with a 1-cycle mem_ack (grant, ack, RESP);
//           2 cycles for an out-of-range address (grant, RESP); a silent
//           backing store is abandoned after TIMEOUT cycles of mem_req.
// Backpressure: requesters hold f_req/d_req until their one-cycle ready
//           pulse; one transaction is in flight at a time, so the loser of
//           an arbitration simply waits in IDLE for its turn.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   f_req, f_addr               fetch read request / word address
//   f_ready, f_rdata, f_err     fetch completion pulse, data, error flag
//   d_req, d_we, d_addr, d_wdata   memory-stage request / command
//   d_ready, d_rdata, d_err     memory-stage completion pulse, data, error
//   mem_req, mem_we, mem_addr, mem_wdata   command to the backing store
//   mem_ack, mem_rdata          backing store completion and read data
module data_mem_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [63:0] ADDR_MAX = 64'd8191
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_ready,
  output logic [63:0] f_rdata,
  output logic        f_err,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ready,
  output logic [63:0] d_rdata,
  output logic        d_err,

  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Owner / last_grant encoding: 0 = fetch, 1 = data.
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t        state;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] cnt;

  // Arbitration decision, only meaningful in IDLE.
  logic          any_req;
  logic          grant_d;
  logic [63:0]   sel_addr;
  logic          sel_bad;

  always_comb begin
    any_req  = f_req | d_req;
    // Data wins if it is alone, or if both are pending and fetch went last.
    grant_d  = d_req & (~f_req | (last_grant == OWN_F));
    sel_addr = grant_d ? d_addr : f_addr;
    // Plain unsigned compare: huge addresses must not wrap to "legal".
    sel_bad  = (sel_addr > ADDR_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_F;
      last_grant <= OWN_F;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      f_ready    <= 1'b0;
      f_err      <= 1'b0;
      f_rdata    <= '0;
      d_ready    <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            // Latch the whole command so the requester's inputs may wander.
            owner     <= grant_d ? OWN_D : OWN_F;
            mem_we    <= grant_d ? d_we : 1'b0;
            mem_addr  <= sel_addr;
            mem_wdata <= grant_d ? d_wdata : 64'd0;
            cnt       <= '0;
            if (sel_bad) begin
              // Never touch the backing store; answer with an error now.
              state <= RESP;
              if (grant_d) begin
                d_ready <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                f_ready <= 1'b1;
                f_err   <= 1'b1;
                f_rdata <= '0;
              end
            end else begin
              state   <= BUSY;
              mem_req <= 1'b1;
            end
          end
        end

        BUSY: begin
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (owner == OWN_D) begin
              d_ready <= 1'b1;
              d_err   <= 1'b0;
              // Writes return no data.
              d_rdata <= mem_we ? 64'd0 : mem_rdata;
            end else begin
              f_ready <= 1'b1;
              f_err   <= 1'b0;
              f_rdata <= mem_rdata;
            end
          end else if (cnt == CNT_LAST) begin
            // Backing store went quiet: give up and report an error.
            state   <= RESP;
            mem_req <= 1'b0;
            if (owner == OWN_D) begin
              d_ready <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              f_ready <= 1'b1;
              f_err   <= 1'b1;
              f_rdata <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RESP: begin
          // The ready pulse lasts exactly this one cycle.
          state      <= IDLE;
          last_grant <= owner;
          f_ready    <= 1'b0;
          f_err      <= 1'b0;
          d_ready    <= 1'b0;
          d_err      <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          f_ready <= 1'b0;
          d_ready <= 1'b0;
          f_err   <= 1'b0;
          d_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Purpose : directed, table-driven check of data_mem_arbiter plus
//           hand-written timeout and mid-transaction reset sequences.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req, d_we, mem_ack;
  logic [63:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic        f_ready, f_err, d_ready, d_err;
  logic [63:0] f_rdata, d_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.TIMEOUT(16), .ADDR_MAX(64'd8191)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        f_req;
    logic [63:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        ack;
    logic [63:0] mrd;
    logic        e_mreq;
    logic        e_mwe;
    logic [63:0] e_maddr;
    logic [63:0] e_mwdata;
    logic        e_fr;
    logic        e_fe;
    logic [63:0] e_frd;
    logic        e_dr;
    logic        e_de;
    logic [63:0] e_drd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fr, input logic [63:0] fa, input logic dr, input logic dw,
                     input logic [63:0] da, input logic [63:0] dwd, input logic ak,
                     input logic [63:0] mr, input logic emq, input logic emw,
                     input logic [63:0] ema, input logic [63:0] emd, input logic efr,
                     input logic efe, input logic [63:0] efd, input logic edr,
                     input logic ede, input logic [63:0] edd);
    vec_t v;
    v.f_req = fr;  v.f_addr = fa;  v.d_req = dr;  v.d_we = dw;
    v.d_addr = da; v.d_wdata = dwd; v.ack = ak;   v.mrd = mr;
    v.e_mreq = emq; v.e_mwe = emw; v.e_maddr = ema; v.e_mwdata = emd;
    v.e_fr = efr; v.e_fe = efe; v.e_frd = efd;
    v.e_dr = edr; v.e_de = ede; v.e_drd = edd;
    tbl.push_back(v);
  endtask

  initial begin
    int   hi;
    logic seen;
    logic t_err, t_mreq;
    logic [63:0] t_rd;

    rst_n = 1'b0; f_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

    // Columns: f_req f_addr | d_req d_we d_addr d_wdata | ack mem_rdata ||
    //          exp mem_req mem_we mem_addr mem_wdata | f_ready f_err f_rdata | d_ready d_err d_rdata
    // Single fetch read, ack after one cycle.
    add(1, 64'h10, 0, 0, 0, 0, 0, 0,          1, 0, 64'h10, 0,  0, 0, 0,          0, 0, 0);
    add(1, 64'h10, 0, 0, 0, 0, 1, 64'hABCD,   0, 0, 0, 0,       1, 0, 64'hABCD,   0, 0, 0);
    add(0, 64'h10, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0,       0, 0, 0,          0, 0, 0);
    // Stray mem_ack while idle is ignored.
    add(0, 0, 0, 0, 0, 0, 1, 64'hDEAD,        0, 0, 0, 0,       0, 0, 0,          0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0,       0, 0, 0,          0, 0, 0);
    // Contention after a fetch: data write wins first.
    add(1, 64'h20, 1, 1, 5, 7, 0, 0,          1, 1, 5, 7,       0, 0, 0,          0, 0, 0);
    add(1, 64'h20, 1, 1, 5, 7, 1, 64'h999,    0, 0, 0, 0,       0, 0, 0,          1, 0, 0);
    add(1, 64'h20, 1, 1, 5, 7, 0, 0,          0, 0, 0, 0,       0, 0, 0,          0, 0, 0);
    // Data re-requests at once; the next contention goes to fetch.
    add(1, 64'h20, 1, 1, 5, 7, 0, 0,          1, 0, 64'h20, 0,  0, 0, 0,          0, 0, 0);
    add(1, 64'h20, 1, 1, 5, 7, 1, 64'h1234,   0, 0, 0, 0,       1, 0, 64'h1234,   0, 0, 0);
    add(0, 64'h20, 1, 1, 5, 7, 0, 0,          0, 0, 0, 0,       0, 0, 0,          0, 0, 0);
    add(0, 64'h20, 1, 1, 5, 7, 0, 0,          1, 1, 5, 7,       0, 0, 0,          0, 0, 0);
    add(0, 64'h20, 1, 1, 5, 7, 1, 64'h55,     0, 0, 0, 0,       0, 0, 0,          1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0,       0, 0, 0,          0, 0, 0);
    // Out-of-range data address: error response, no backing-store access.
    add(0, 0, 1, 0, 64'd8192, 0, 0, 0,        0, 0, 0, 0,       0, 0, 0,          1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0,       0, 0, 0,          0, 0, 0);
    // All-ones fetch address must be rejected (unsigned compare).
    add(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 1, 64'h77, 0, 0, 0, 0, 1, 1, 0,   0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 64'h77,          0, 0, 0, 0,       0, 0, 0,          0, 0, 0);

    #12;
    chk("reset.mem_req", {63'd0, mem_req}, 64'd0);
    chk("reset.mem_we", {63'd0, mem_we}, 64'd0);
    chk("reset.mem_addr", mem_addr, 64'd0);
    chk("reset.mem_wdata", mem_wdata, 64'd0);
    chk("reset.readies", {62'd0, f_ready, d_ready}, 64'd0);
    chk("reset.errs", {62'd0, f_err, d_err}, 64'd0);
    chk("reset.f_rdata", f_rdata, 64'd0);
    chk("reset.d_rdata", d_rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      f_req = tbl[i].f_req;  f_addr = tbl[i].f_addr;
      d_req = tbl[i].d_req;  d_we = tbl[i].d_we;
      d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
      mem_ack = tbl[i].ack;  mem_rdata = tbl[i].mrd;
      step();
      chk($sformatf("row%0d.mem_req", i), {63'd0, mem_req}, {63'd0, tbl[i].e_mreq});
      chk($sformatf("row%0d.f_ready", i), {63'd0, f_ready}, {63'd0, tbl[i].e_fr});
      chk($sformatf("row%0d.d_ready", i), {63'd0, d_ready}, {63'd0, tbl[i].e_dr});
      if (tbl[i].e_mreq) begin
        chk($sformatf("row%0d.mem_we", i), {63'd0, mem_we}, {63'd0, tbl[i].e_mwe});
        chk($sformatf("row%0d.mem_addr", i), mem_addr, tbl[i].e_maddr);
        if (tbl[i].e_mwe)
          chk($sformatf("row%0d.mem_wdata", i), mem_wdata, tbl[i].e_mwdata);
      end
      if (tbl[i].e_fr) begin
        chk($sformatf("row%0d.f_err", i), {63'd0, f_err}, {63'd0, tbl[i].e_fe});
        chk($sformatf("row%0d.f_rdata", i), f_rdata, tbl[i].e_frd);
      end
      if (tbl[i].e_dr) begin
        chk($sformatf("row%0d.d_err", i), {63'd0, d_err}, {63'd0, tbl[i].e_de});
        chk($sformatf("row%0d.d_rdata", i), d_rdata, tbl[i].e_drd);
      end
    end

    // Timeout at the highest legal address: mem_req for exactly 16 cycles.
    f_req = 0; d_req = 1; d_we = 0; d_addr = 64'd8191; d_wdata = 0; mem_ack = 0;
    hi = 0; seen = 0; t_err = 0; t_mreq = 1; t_rd = '1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (mem_req) hi++;
      if (d_ready) begin
        seen = 1; t_err = d_err; t_rd = d_rdata; t_mreq = mem_req;
        break;
      end
    end
    chk("timeout.ready_seen", {63'd0, seen}, 64'd1);
    chk("timeout.mem_req_cycles", 64'(hi), 64'd16);
    chk("timeout.d_err", {63'd0, t_err}, 64'd1);
    chk("timeout.d_rdata", t_rd, 64'd0);
    chk("timeout.mem_req_dropped", {63'd0, t_mreq}, 64'd0);
    d_req = 0;
    step();
    step();

    // Reset in the middle of a transaction.
    f_req = 1; f_addr = 64'h30;
    step();
    chk("rst.busy_mem_req", {63'd0, mem_req}, 64'd1);
    #2;
    rst_n = 1'b0;
    f_req = 0;
    #1;
    chk("rst.mem_req_async", {63'd0, mem_req}, 64'd0);
    chk("rst.mem_addr_async", mem_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1; mem_rdata = 64'h77;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("rst.quiet%0d", c), {62'd0, f_ready | d_ready, mem_req}, 64'd0);
    end
    // last_grant is back to fetch, so data wins this contention.
    mem_ack = 0;
    f_req = 1; f_addr = 64'h40; d_req = 1; d_we = 0; d_addr = 64'h50;
    step();
    chk("rst.regrant_mem_req", {63'd0, mem_req}, 64'd1);
    chk("rst.regrant_addr", mem_addr, 64'h50);
    mem_ack = 1; mem_rdata = 64'h5A;
    step();
    chk("rst.d_ready", {63'd0, d_ready}, 64'd1);
    chk("rst.d_rdata", d_rdata, 64'h5A);
    chk("rst.f_ready_quiet", {63'd0, f_ready}, 64'd0);
    d_req = 0; mem_ack = 0;
    step();
    step();
    chk("rst.f_grant_addr", mem_addr, 64'h40);
    mem_ack = 1; mem_rdata = 64'h4F;
    step();
    chk("rst.f_ready", {63'd0, f_ready}, 64'd1);
    chk("rst.f_rdata", f_rdata, 64'h4F);
    f_req = 0; mem_ack = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum cycles to wait for mem_ack before aborting a transaction.
REQ-002 Parameter: ADDR_MAX, default 8191, highest legal word address.
REQ-003 clk  in  1  single clock, all state on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 f_req  in  1  fetch read request, held until f_ready.
REQ-006 f_addr  in  64  fetch word address.
REQ-007 d_req  in  1  memory-stage request, held until d_ready.
REQ-008 d_we  in  1  memory-stage write (1) / read (0).
REQ-009 d_addr  in  64  memory-stage word address.
REQ-010 d_wdata  in  64  memory-stage write data.
REQ-011 f_ready, d_ready  out  1 each  one-cycle completion pulse to the requester.
REQ-012 f_rdata, d_rdata  out  64 each  read data, valid while the matching ready is high.
REQ-013 f_err, d_err  out  1 each  error flag (address out of range or timeout), valid with ready.
REQ-014 mem_req  out  1  request to the backing store.
REQ-015 mem_we, mem_addr (64), mem_wdata (64)  out  command to the backing store.
REQ-016 mem_ack  in  1  backing store completion; mem_rdata  in  64  read data, valid with mem_ack.

Function
REQ-017 FSM states: IDLE, BUSY, RESP.
REQ-018 IDLE: with no request pending, remain in IDLE.
REQ-019 IDLE, exactly one request pending: grant it.
REQ-020 IDLE, both requests pending: grant the requester not granted last (round-robin); last_grant bit resets to "fetch", so d wins the first contention.
REQ-021 At grant, latch owner, we (fetch: 0), addr and wdata; later changes on the request inputs are ignored until RESP.
REQ-022 Grant with latched addr > ADDR_MAX: go to RESP with err=1, rdata=0, no mem_req issued.
REQ-023 Grant with legal address: go to BUSY, clear the timeout counter.
REQ-024 BUSY: mem_req=1 with latched mem_we/mem_addr/mem_wdata held stable.
REQ-025 BUSY: counter increments each cycle without mem_ack.
REQ-026 BUSY with mem_ack=1: register mem_rdata (0 for writes), err=0, go to RESP.
REQ-027 BUSY with counter reaching TIMEOUT-1 and no mem_ack: drop mem_req, err=1, rdata=0, go to RESP.
REQ-028 RESP (one cycle): owner's ready=1 with latched rdata/err; the other ready stays 0; update last_grant; return to IDLE.
REQ-029 Minimum latency req->ready is 3 cycles (grant, 1-cycle ack, RESP); the out-of-range path is 2 cycles.
REQ-030 mem_req is 0 in IDLE and RESP; mem_ack outside BUSY is ignored.
REQ-031 Address compare is unsigned 64-bit; ADDR_MAX itself is legal.

Reset
REQ-032 rst_n low asynchronously forces IDLE, counter=0, last_grant=fetch, mem_req=0, all ready/err=0, all rdata/mem_addr/mem_wdata=0, mem_we=0.
REQ-033 Reset during BUSY aborts the transaction silently: no ready pulse follows, and the requester re-requests.

Verification
REQ-034 f_req only, f_addr=0x10, mem_ack after 1 cycle with rdata 0xABCD -> f_ready one cycle, f_rdata=0xABCD, f_err=0.
REQ-035 f_req and d_req together, d_we=1, d_addr=5, d_wdata=7 -> data served first (mem_we=1, mem_addr=5, mem_wdata=7), then fetch served; with the next simultaneous pair, fetch wins.
REQ-036 d_req, d_addr=8192 -> d_ready two cycles after request, d_err=1, d_rdata=0, mem_req never asserted.
REQ-037 d_req, d_addr=8191, mem_ack never -> mem_req high exactly 16 cycles, then d_ready with d_err=1.
REQ-038 rst_n pulled low mid-BUSY -> mem_req=0 immediately, no ready pulse afterwards, next request is granted normally.
REQ-039 mem_ack asserted while IDLE -> no state change, no ready pulse.
